// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler
//
// Round-robin scheduler for one shared N-to-1 mux datapath. It arbitrates
// the request lines, drives the mux select, and holds each grant for up to
// BURST_LEN accepted beats. The grant is released early if the owner drops
// its request. Exactly one IDLE cycle separates consecutive grants, which
// gives the mux select time to settle.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req[N]     per-requester request level (held while data is present)
//   i_ready      consumer accepts the current beat
//   o_sel        mux select: index of the current or most recent winner
//   o_gnt[N]     one-hot grant, all zeros while idle
//   o_valid      mux output carries a valid beat
//   o_beat_cnt   beats accepted so far in the current grant
//   o_fsm_state  debug view of the FSM (0 = IDLE, 1 = GRANT)
//
// Handshake: a beat transfers on a rising edge where o_valid and i_ready
// are both high. o_valid depends only on registered state and i_req, and
// never on i_ready, so a consumer may derive i_ready from o_valid.

module mux_rr_scheduler #(
  parameter int WIDTH_SELECT = 2,
  parameter int N            = 2**WIDTH_SELECT,
  parameter int BURST_LEN    = 4,
  parameter int CNT_W        = $clog2(BURST_LEN+1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N-1:0]            i_req,
  input  logic                    i_ready,
  output logic [WIDTH_SELECT-1:0] o_sel,
  output logic [N-1:0]            o_gnt,
  output logic                    o_valid,
  output logic [CNT_W-1:0]        o_beat_cnt,
  output logic                    o_fsm_state
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t                  state_q, state_d;
  logic [WIDTH_SELECT-1:0] ptr_q, ptr_d;
  logic [WIDTH_SELECT-1:0] sel_q, sel_d;
  logic [N-1:0]            gnt_q, gnt_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    win_found;
  logic [WIDTH_SELECT-1:0] win_idx;
  logic [WIDTH_SELECT-1:0] cand;
  logic                    owner_req;
  logic                    beat;

  // Winner search: walk the requesters in priority order starting at ptr.
  // Adding the offset in WIDTH_SELECT bits gives the wrap past N-1 for free,
  // since N is always 2**WIDTH_SELECT.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr_q + WIDTH_SELECT'(i);
      if (!win_found && i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // The owner's own request line is the only one that matters during a grant.
  assign owner_req = i_req[sel_q];
  assign o_valid   = (state_q == ST_GRANT) && owner_req;
  assign beat      = o_valid && i_ready;

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d        = ST_GRANT;
          sel_d          = win_idx;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          cnt_d          = '0;
        end
      end

      ST_GRANT: begin
        // Release on an owner drop, or on the final beat of the burst.
        // The served requester becomes lowest priority; o_sel is kept so the
        // mux input stays stable through the gap cycle.
        if (!owner_req || (beat && (cnt_q == LAST_BEAT))) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = sel_q + WIDTH_SELECT'(1);
        end else if (beat) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_sel       = sel_q;
  assign o_gnt       = gnt_q;
  assign o_beat_cnt  = cnt_q;
  assign o_fsm_state = (state_q == ST_GRANT);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler (N=4, BURST_LEN=4).
// A reference model written in terms of "who owns the mux, how many beats it
// has delivered, who is next in line" predicts, for every clock cycle, the
// expected o_valid/o_gnt pair and, for every accepted beat, the expected
// o_sel/o_beat_cnt. A monitor on the falling edge pops and compares.

module tb_mux_rr_scheduler;

  localparam int WS        = 2;
  localparam int N         = 4;
  localparam int BURST_LEN = 4;
  localparam int CNT_W     = $clog2(BURST_LEN + 1);
  localparam int BW        = WS + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]     i_req;
  logic             i_ready;
  logic [WS-1:0]    o_sel;
  logic [N-1:0]     o_gnt;
  logic             o_valid;
  logic [CNT_W-1:0] o_beat_cnt;
  logic             o_fsm_state;

  mux_rr_scheduler #(
    .WIDTH_SELECT(WS),
    .N(N),
    .BURST_LEN(BURST_LEN),
    .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req(i_req),
    .i_ready(i_ready),
    .o_sel(o_sel),
    .o_gnt(o_gnt),
    .o_valid(o_valid),
    .o_beat_cnt(o_beat_cnt),
    .o_fsm_state(o_fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [N:0]    cyc_q[$];   // {valid, gnt} expected per cycle
  logic [BW-1:0] exp_q[$];   // {sel, beat_cnt} expected per accepted beat

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  int m_owner = -1;  // requester holding the mux, -1 when nobody does
  int m_beats = 0;   // beats delivered by the owner in this grant
  int m_next  = 0;   // requester with highest priority for the next grant

  function automatic void model_reset();
    m_owner = -1;
    m_beats = 0;
    m_next  = 0;
  endfunction

  // Called once per cycle with that cycle's inputs: records what the
  // outputs must show in this cycle, then advances to the next cycle.
  function automatic void model_step(input logic [N-1:0] req, input logic rdy);
    logic         v;
    logic [N-1:0] g;
    bit           found;
    g = '0;
    v = 1'b0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      v = req[m_owner];
    end
    cyc_q.push_back({v, g});

    if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_next + k) % N]) begin
          found   = 1;
          m_owner = (m_next + k) % N;
          m_beats = 0;
        end
      end
    end else if (!req[m_owner]) begin
      m_next  = (m_owner + 1) % N;
      m_owner = -1;
    end else if (rdy) begin
      exp_q.push_back({WS'(m_owner), CNT_W'(m_beats)});
      m_beats++;
      if (m_beats == BURST_LEN) begin
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endfunction

  // ---------------- monitor ----------------
  logic [N:0]    cyc_e;
  logic [BW-1:0] beat_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cyc_q.size() == 0) begin
        check("cycle_expectation_present", 32'(cyc_q.size()), 32'd1);
      end else begin
        cyc_e = cyc_q.pop_front();
        check("o_valid", 32'(o_valid), 32'(cyc_e[N]));
        check("o_gnt", 32'(o_gnt), 32'(cyc_e[N-1:0]));
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          beat_e = exp_q.pop_front();
          check("beat_sel", 32'(o_sel), 32'(beat_e[BW-1:CNT_W]));
          check("beat_cnt", 32'(o_beat_cnt), 32'(beat_e[CNT_W-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_cycle(input logic [N-1:0] req, input logic rdy);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    i_req   = req;
    i_ready = rdy;
    model_step(req, rdy);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"}, 32'(o_sel), 32'd0);
    check({tag, "_gnt"}, 32'(o_gnt), 32'd0);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_cnt"}, 32'(o_beat_cnt), 32'd0);
    check({tag, "_state"}, 32'(o_fsm_state), 32'd0);
  endtask

  // Reset asserted mid-cycle: outputs must clear without a clock edge.
  task automatic reset_mid_cycle();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    i_req   = '0;
    i_ready = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  logic [N-1:0] req_r;
  logic         rdy_r;
  int           n_rst;

  initial begin
    rst_n   = 1'b0;
    i_req   = '0;
    i_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Idle with no requests: nothing moves, whatever i_ready does.
    for (int i = 0; i < 10; i++) begin
      run_cycle('0, 1'($urandom_range(0, 1)));
      check("idle_sel", 32'(o_sel), 32'd0);
      check("idle_valid", 32'(o_valid), 32'd0);
    end

    // Single requester 2: bursts of 4 with one gap cycle.
    for (int i = 0; i < 12; i++) run_cycle(4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle('0, 1'b1);

    // Everyone requesting: round-robin rotation.
    for (int i = 0; i < 26; i++) run_cycle(4'b1111, 1'b1);

    // Backpressure: ready toggles every cycle.
    for (int i = 0; i < 24; i++) run_cycle(4'b1111, 1'(i % 2 == 0));
    for (int i = 0; i < 3; i++) run_cycle('0, 1'b0);

    // Early drop by requester 3 after two beats, then 4'b1010 from ptr 0.
    run_cycle(4'b1000, 1'b1);
    for (int i = 0; i < 2; i++) run_cycle(4'b1000, 1'b1);
    run_cycle(4'b0000, 1'b1);
    for (int i = 0; i < 6; i++) run_cycle(4'b1010, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle('0, 1'b0);

    // Random traffic with occasional mid-burst resets.
    req_r = '0;
    n_rst = 0;
    for (int i = 0; i < 2000; i++) begin
      if (n_rst < 4 && m_owner >= 0 && m_beats == 2 && $urandom_range(0, 2) == 0) begin
        reset_mid_cycle();
        n_rst++;
        req_r = 4'b1000;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (req_r[k]) req_r[k] = ($urandom_range(0, 7) != 0);
          else          req_r[k] = ($urandom_range(0, 3) == 0);
        end
      end
      rdy_r = ($urandom_range(0, 3) != 0);
      run_cycle(req_r, rdy_r);
    end

    // Drain.
    for (int i = 0; i < 6; i++) run_cycle('0, 1'b0);
    @(negedge clk);
    #1;
    check("resets_exercised", 32'(n_rst > 0), 32'd1);
    check("beats_left", 32'(exp_q.size()), 32'd0);
    check("cycles_left", 32'(cyc_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
